// File: rtl/aes_pkg.sv
// Shared types, sizes and GF(2^8) arithmetic for the inverse AES byte-serial datapath.
package aes_pkg;

   localparam int AES_NR       = 10;
   localparam int AES_NB_BYTES = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ROUND,
      UNLOAD
   } dp_state_t;

   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ p;
         p = gf_xtime(p);
      end
      return acc;
   endfunction

   // Column packed with row 0 in the top byte.
   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      {a0, a1, a2, a3} = col;
      b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      return {b0, b1, b2, b3};
   endfunction

endpackage

// File: rtl/aes_inv_data_path_sbox.sv
// Combinational AES inverse S-box: inverse affine map followed by GF(2^8) inversion (x^254).
module bInvSbox
   import aes_pkg::*;
(
   input  logic [7:0] sbox_in,
   output logic [7:0] sbox_out
);

   logic [7:0] t, t2, t3, t6, t12, t15, t30, t60, t120, t240, t252;

   // Addition chain for x^254; zero maps to zero as the S-box requires.
   always_comb begin
      t    = {sbox_in[6:0], sbox_in[7]} ^ {sbox_in[4:0], sbox_in[7:5]}
           ^ {sbox_in[1:0], sbox_in[7:2]} ^ 8'h05;
      t2   = gf_mul(t, t);
      t3   = gf_mul(t2, t);
      t6   = gf_mul(t3, t3);
      t12  = gf_mul(t6, t6);
      t15  = gf_mul(t12, t3);
      t30  = gf_mul(t15, t15);
      t60  = gf_mul(t30, t30);
      t120 = gf_mul(t60, t60);
      t240 = gf_mul(t120, t120);
      t252 = gf_mul(t240, t12);
      sbox_out = gf_mul(t252, t2);
   end

endmodule

// File: rtl/aes_inv_data_path.sv
// Byte-serial AES-128 decryption datapath with an external round-key store.
// Optional AES_INV_DP_LAT_CNT_EN adds the lat_cnt busy-cycle counter output.
module aes_inv_data_path
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [3:0] rk_round,
   output logic [3:0] rk_idx,
   input  logic [7:0] rk_byte,
   output logic [7:0] dout,
   output logic       dout_valid,
   input  logic       dout_ready,
   output logic       busy
`ifdef AES_INV_DP_LAT_CNT_EN
   ,
   output logic [7:0] lat_cnt
`endif
);

   localparam logic [3:0] LAST_BYTE = 4'(AES_NB_BYTES - 1);

   dp_state_t   cur_st, nxt_st;
   logic [7:0]  state_q [AES_NB_BYTES];
   logic [7:0]  buf_q   [AES_NB_BYTES];
   logic [3:0]  cnt_q;
   logic [3:0]  round_cnt;

   logic [1:0]  row, col, src_col;
   logic [3:0]  src_idx;
   logic [7:0]  sb_in, sb_out, sub_byte;
   logic [31:0] raw_col, mixed_col, done_col;

   // Byte i of the round sits at (row i%4, col i/4) and reads its InvShiftRows source.
   always_comb begin
      row       = cnt_q[1:0];
      col       = cnt_q[3:2];
      src_col   = col - row;
      src_idx   = {src_col, row};
      sb_in     = state_q[src_idx];
      sub_byte  = sb_out ^ rk_byte;
      raw_col   = {buf_q[{col, 2'd0}], buf_q[{col, 2'd1}], buf_q[{col, 2'd2}], sub_byte};
      mixed_col = inv_mix_column(raw_col);
      done_col  = (round_cnt == 4'd0) ? raw_col : mixed_col;
   end

   bInvSbox u_inv_sbox (
      .sbox_in  (sb_in),
      .sbox_out (sb_out)
   );

   always_ff @(posedge clk) begin
      if (rst) cur_st <= IDLE;
      else     cur_st <= nxt_st;
   end

   // The IDLE transfer is load beat 0, so it addresses k10[0] while it happens.
   always_comb begin
      nxt_st     = cur_st;
      din_ready  = 1'b0;
      dout_valid = 1'b0;
      rk_round   = 4'd0;
      rk_idx     = 4'd0;
      case (cur_st)
         IDLE: begin
            din_ready = 1'b1;
            if (din_valid) begin
               rk_round = 4'(AES_NR);
               nxt_st   = LOAD;
            end
         end
         LOAD: begin
            din_ready = 1'b1;
            rk_round  = 4'(AES_NR);
            rk_idx    = cnt_q;
            if (din_valid && cnt_q == LAST_BYTE) nxt_st = ROUND;
         end
         ROUND: begin
            rk_round = round_cnt;
            rk_idx   = cnt_q;
            if (cnt_q == LAST_BYTE && round_cnt == 4'd0) nxt_st = UNLOAD;
         end
         UNLOAD: begin
            dout_valid = 1'b1;
            if (dout_ready && cnt_q == LAST_BYTE) nxt_st = IDLE;
         end
         default: nxt_st = IDLE;
      endcase
   end

   assign busy = (cur_st != IDLE);
   assign dout = (cur_st == UNLOAD) ? state_q[cnt_q] : 8'h00;

   // One shared byte counter walks load, each round and unload, wrapping 15->0 between phases.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= 4'd0;
         round_cnt <= 4'd0;
         for (int k = 0; k < AES_NB_BYTES; k++) begin
            state_q[k] <= 8'h00;
            buf_q[k]   <= 8'h00;
         end
      end else begin
         case (cur_st)
            IDLE: begin
               if (din_valid) begin
                  state_q[0] <= din ^ rk_byte;
                  cnt_q      <= 4'd1;
               end
            end
            LOAD: begin
               if (din_valid) begin
                  state_q[cnt_q] <= din ^ rk_byte;
                  cnt_q          <= cnt_q + 4'd1;
                  if (cnt_q == LAST_BYTE) round_cnt <= 4'(AES_NR - 1);
               end
            end
            ROUND: begin
               cnt_q <= cnt_q + 4'd1;
               if (row != 2'd3) begin
                  buf_q[cnt_q] <= sub_byte;
               end else begin
                  buf_q[{col, 2'd0}] <= done_col[31:24];
                  buf_q[{col, 2'd1}] <= done_col[23:16];
                  buf_q[{col, 2'd2}] <= done_col[15:8];
                  buf_q[{col, 2'd3}] <= done_col[7:0];
               end
               // State must stay untouched mid-round because later bytes still read it.
               if (cnt_q == LAST_BYTE) begin
                  for (int k = 0; k < AES_NB_BYTES - 4; k++) state_q[k] <= buf_q[k];
                  state_q[12] <= done_col[31:24];
                  state_q[13] <= done_col[23:16];
                  state_q[14] <= done_col[15:8];
                  state_q[15] <= done_col[7:0];
                  if (round_cnt != 4'd0) round_cnt <= round_cnt - 4'd1;
               end
            end
            UNLOAD: begin
               if (dout_ready) cnt_q <= cnt_q + 4'd1;
            end
            default: cnt_q <= 4'd0;
         endcase
      end
   end

`ifdef AES_INV_DP_LAT_CNT_EN
   // Counts busy cycles of the current block and freezes once the block returns to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_cnt <= 8'd0;
      end else if (cur_st == IDLE) begin
         if (nxt_st != IDLE) lat_cnt <= 8'd0;
      end else if (lat_cnt != 8'hff) begin
         lat_cnt <= lat_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: doc/aes_inv_data_path.md
AES_INV_DATA_PATH -- requirements
Module: aes_inv_data_path

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and the single clock; all state updates on its rising edge.
REQ-002 The port rst SHALL be an input, 1 bit wide, with synchronous, active-high reset.
REQ-003 The port din SHALL be an input, 8 bits wide, carrying a ciphertext byte; byte 0 (FIPS-197 in0, MSB of 128-bit block) first, column-major.
REQ-004 The ports din_valid (input, 1 bit) and din_ready (output, 1 bit) SHALL form the input handshake; a transfer occurs when both are high on a clock edge.
REQ-005 The port rk_round SHALL be an output, 4 bits wide, giving the round-key index requested (10..0).
REQ-006 The port rk_idx SHALL be an output, 4 bits wide, giving the round-key byte index requested (0..15).
REQ-007 The port rk_byte SHALL be an input, 8 bits wide, carrying the key byte for {rk_round, rk_idx}; an external key store returns it combinationally in the same cycle.
REQ-008 The port dout SHALL be an output, 8 bits wide, carrying a plaintext byte, in the same byte order as din.
REQ-009 The ports dout_valid (output, 1 bit) and dout_ready (input, 1 bit) SHALL form the output handshake; a transfer occurs when both are high on a clock edge.
REQ-010 The port busy SHALL be an output, 1 bit wide, high in every state except IDLE.

Function
REQ-011 The FSM SHALL have the states IDLE, LOAD, ROUND and UNLOAD.
REQ-012 The block SHALL move IDLE->LOAD on the first din transfer and LOAD->ROUND after 16 accepted bytes.
REQ-013 The block SHALL move ROUND->UNLOAD after round 0 completes, and UNLOAD->IDLE after 16 output transfers.
REQ-014 In LOAD, each accepted byte i SHALL be stored as din^k10[i] (rk_round=10, rk_idx=i); din_ready is high in IDLE/LOAD only.
REQ-015 In ROUND r (r=9 down to 0), each cycle i (0..15) SHALL compute InvSbox(state[InvShiftRows source of i]) ^ kr[i] into a next-state buffer.
REQ-016 In ROUND, InvShiftRows source for output position (row c, col j) SHALL be state(row c, col (j-c) mod 4).
REQ-017 When r≠0, on completion of each column (i=3,7,11,15) the block SHALL apply InvMixColumns to that column's 4 bytes before storing them; in round 0 it SHALL skip InvMixColumns.
REQ-018 The block SHALL copy the next-state buffer to state at i=15 of each round; each round takes exactly 16 cycles and ROUND totals 160 cycles.
REQ-019 In UNLOAD, dout SHALL present state byte k and hold it stable while dout_ready is low; dout_valid stays high until byte 15 transfers.
REQ-020 Block latency SHALL be 16 load + 160 round + 16 unload cycles with no stalls; din_valid drops during LOAD pause loading without corrupting the byte count.
REQ-021 rk_round/rk_idx SHALL be 0 outside LOAD/ROUND.

Reset
REQ-022 On rst the block SHALL go to IDLE with din_ready=1, dout_valid=0, dout=0, busy=0, rk_round=0, rk_idx=0, all counters and state cleared.
REQ-023 rst asserted mid-LOAD, mid-ROUND or mid-UNLOAD SHALL abort the block with no partial output; the first cycle after reset behaves as IDLE.

Configuration
REQ-024 With AES_INV_DP_LAT_CNT_EN defined, the block SHALL add output lat_cnt[7:0], which clears on leaving IDLE, increments every busy cycle, saturates at 255 and holds in IDLE.
REQ-025 Without AES_INV_DP_LAT_CNT_EN, the lat_cnt port and its logic SHALL be absent.

Structure
REQ-026 The package aes_pkg SHALL hold the state enum, AES_NR=10, AES_NB_BYTES=16 and the GF(2^8) xtime/multiply functions used by InvMixColumns.
REQ-027 The inverse S-box SHALL be one sub-module, bInvSbox (8-bit in, 8-bit out, combinational).

Verification
REQ-028 FIPS-197 C.1: key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, with exactly 192 cycles from first din transfer to last dout transfer (dout_ready=1 throughout).
REQ-029 FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
REQ-030 Backpressure: dout_ready low for 5 cycles at byte 7 -> dout holds byte 7 stable and the full plaintext is still correct.
REQ-031 Input gaps: din_valid toggled 1/0 during LOAD -> exactly 16 bytes accepted and the C.1 result is correct.
REQ-032 Reset at ROUND cycle 50 -> busy=0 and din_ready=1 next cycle, no dout_valid, and the following C.1 block decrypts correctly.
REQ-033 With AES_INV_DP_LAT_CNT_EN defined, lat_cnt=191 at the last dout transfer of the C.1 run.
